// File: rtl/adder_scheduler.sv
// Two-requester round-robin front end for a single shared multi-cycle FP adder.
// Accepts one operation at a time, drives the adder and holds the captured result until consumed.
module adder_scheduler #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8,
  parameter int TIMEOUT       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic                                 req0_valid,
  output logic                                 req0_ready,
  input  logic [Mantissa_Size+Exponent_Size:0] req0_a,
  input  logic [Mantissa_Size+Exponent_Size:0] req0_b,
  input  logic                                 req0_sub,

  input  logic                                 req1_valid,
  output logic                                 req1_ready,
  input  logic [Mantissa_Size+Exponent_Size:0] req1_a,
  input  logic [Mantissa_Size+Exponent_Size:0] req1_b,
  input  logic                                 req1_sub,

  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic                                 resp_id,
  output logic [Mantissa_Size+Exponent_Size:0] resp_result,
  output logic [4:0]                           resp_flags,

  output logic                                 add_enable,
  output logic                                 add_load,
  output logic [Mantissa_Size+Exponent_Size:0] add_A,
  output logic [Mantissa_Size+Exponent_Size:0] add_B,
  input  logic [Mantissa_Size+Exponent_Size:0] add_result,
  input  logic                                 add_done,
  input  logic                                 add_overflow,
  input  logic                                 add_underflow,
  input  logic                                 add_zero,
  input  logic                                 add_nan
);

  localparam int W  = Mantissa_Size + Exponent_Size + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, RESP} state_t;

  state_t         state_reg;
  logic           last_grant_reg;
  logic           op_id_reg;
  logic [CW-1:0]  count_reg;
  logic           resp_valid_reg;
  logic           resp_id_reg;
  logic [W-1:0]   resp_result_reg;
  logic [4:0]     resp_flags_reg;
  logic           add_enable_reg;
  logic           add_load_reg;
  logic [W-1:0]   add_a_reg;
  logic [W-1:0]   add_b_reg;

  logic [1:0]     req_valid;
  logic [1:0]     req_sub;
  logic [1:0]     ready_vec;
  logic [W-1:0]   req_a [2];
  logic [W-1:0]   req_b [2];
  logic           grant_id;
  logic           transfer;
  logic [W-1:0]   grant_a;
  logic [W-1:0]   grant_b;
  logic           grant_sub;

  assign req_valid = {req1_valid, req0_valid};
  assign req_sub   = {req1_sub, req0_sub};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  // Under contention the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    grant_id = req_valid[1];
    if (&req_valid) begin
      grant_id = ~last_grant_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = ~rst && (state_reg == IDLE) && req_valid[gi]
                             && (grant_id == 1'(gi));
    end
  endgenerate

  assign transfer  = |ready_vec;
  assign grant_a   = req_a[grant_id];
  assign grant_b   = req_b[grant_id];
  assign grant_sub = req_sub[grant_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      op_id_reg       <= 1'b0;
      count_reg       <= '0;
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= 1'b0;
      resp_result_reg <= '0;
      resp_flags_reg  <= '0;
      add_enable_reg  <= 1'b0;
      add_load_reg    <= 1'b0;
      add_a_reg       <= '0;
      add_b_reg       <= '0;
    end else begin
      add_enable_reg <= 1'b1;
      add_load_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            add_a_reg      <= grant_a;
            add_b_reg      <= {grant_b[W-1] ^ grant_sub, grant_b[W-2:0]};
            op_id_reg      <= grant_id;
            last_grant_reg <= grant_id;
            add_load_reg   <= 1'b1;
            state_reg      <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= SETTLE;
        end
        SETTLE: begin
          // add_done may still reflect the previous operation here, so it is not looked at.
          count_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (add_done) begin
            resp_result_reg <= add_result;
            resp_flags_reg  <= {1'b0, add_nan, add_zero, add_underflow, add_overflow};
            resp_id_reg     <= op_id_reg;
            resp_valid_reg  <= 1'b1;
            state_reg       <= RESP;
          end else if (count_reg == LAST_COUNT) begin
            resp_result_reg <= '0;
            resp_flags_reg  <= 5'b10000;
            resp_id_reg     <= op_id_reg;
            resp_valid_reg  <= 1'b1;
            state_reg       <= RESP;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = ready_vec[0];
  assign req1_ready  = ready_vec[1];
  assign resp_valid  = resp_valid_reg;
  assign resp_id     = resp_id_reg;
  assign resp_result = resp_result_reg;
  assign resp_flags  = resp_flags_reg;
  assign add_enable  = add_enable_reg;
  assign add_load    = add_load_reg;
  assign add_A       = add_a_reg;
  assign add_B       = add_b_reg;

endmodule

// File: tb/tb_adder_scheduler.sv
// Scenario bench for adder_scheduler with a behavioural adder stand-in and an expected-response queue.
// Each test task drives requests, pushes expectations and compares responses as they appear.
module tb_adder_scheduler;

  localparam int MS = 23;
  localparam int ES = 8;
  localparam int TO = 32;
  localparam int W  = MS + ES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp_ready = 1'b0;
  logic         req0_ready, req1_ready;
  logic         resp_valid, resp_id;
  logic [W-1:0] resp_result;
  logic [4:0]   resp_flags;
  logic         add_enable, add_load;
  logic [W-1:0] add_A, add_B;
  logic [W-1:0] add_result;
  logic         add_done, add_overflow, add_underflow, add_zero, add_nan;

  adder_scheduler #(.Mantissa_Size(MS), .Exponent_Size(ES), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .add_enable(add_enable), .add_load(add_load), .add_A(add_A), .add_B(add_B),
    .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
    .add_underflow(add_underflow), .add_zero(add_zero), .add_nan(add_nan)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic [4:0]   flags;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   load_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder stand-in: returns {nan, zero, underflow, overflow, result}; known vectors give real FP sums.
  function automatic logic [W+3:0] adder_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h7F000000 && b == 32'h7E7E3B78) return {4'b0000, 32'h7F3F8EDE};
    if (a[W-2:0] == b[W-2:0] && a[W-1] != b[W-1]) return {4'b0100, 32'h00000000};
    if (a[W-2:MS] == '1 && a[MS-1:0] != '0) return {4'b1000, a};
    return {2'b00, a[0] ^ b[0], a[1] ^ b[1], a + b};
  endfunction

  function automatic exp_t expect_op(input logic id, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic sub);
    logic [W-1:0] b_eff;
    logic [W+3:0] r;
    exp_t         e;
    b_eff        = b;
    b_eff[W-1]   = b[W-1] ^ sub;
    r            = adder_fn(a, b_eff);
    e.id         = id;
    e.result     = r[W-1:0];
    e.flags      = {1'b0, r[W+3:W]};
    return e;
  endfunction

  // Done rises model_lat cycles after the load strobe and stays high until the next load.
  logic [W+3:0] model_out = '0;
  logic         model_busy = 1'b0;
  int           model_cnt = 0;
  int           model_lat = 0;
  logic         model_hang = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
    end else if (add_load) begin
      model_busy <= 1'b1;
      model_cnt  <= model_lat;
      model_out  <= adder_fn(add_A, add_B);
      load_cnt   <= load_cnt + 1;
    end else if (model_busy && model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
    end
  end

  assign add_done      = model_busy && (model_cnt == 0) && !model_hang;
  assign add_result    = model_out[W-1:0];
  assign add_overflow  = model_out[W];
  assign add_underflow = model_out[W+1];
  assign add_zero      = model_out[W+2];
  assign add_nan       = model_out[W+3];

  // Presents one request, waits for its handshake, queues the expectation; returns at the LOAD cycle.
  task automatic submit(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output int c);
    int n = 0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    c = cyc;
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL submit_ready id=%0d: ready stayed 0, required 1", id);
    end else begin
      sb.push_back(expect_op(id, a, b, sub));
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(output int rc);
    int n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk); n++;
    end
    rc = cyc;
    if (n >= 100) begin
      total_cnt++;
      $display("FAIL wait_resp: resp_valid stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h0badcafe;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({resp_valid, resp_id, resp_flags, add_load, add_enable} !== 9'b0)
      $display("FAIL reset_ctrl: got %b, required 000000000", {resp_valid, resp_id, resp_flags, add_load, add_enable});
    else pass_cnt++;
    total_cnt++;
    if (resp_result !== '0) $display("FAIL reset_result: got %h, required 00000000", resp_result);
    else pass_cnt++;
    total_cnt++;
    if (add_A !== '0 || add_B !== '0) $display("FAIL reset_operands: got %h/%h, required 0/0", add_A, add_B);
    else pass_cnt++;
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b, required 00", {req1_ready, req0_ready});
    else pass_cnt++;
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (add_enable !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL post_reset: got enable=%b valid=%b, required 1/0", add_enable, resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int   c, rc, loads0;
    exp_t e;
    model_lat = 0; model_hang = 1'b0;
    loads0 = load_cnt;
    submit(1'b0, 32'h7F000000, 32'h7E7E3B78, 1'b0, c);
    req1_valid = 1'b1; #1;
    total_cnt++;
    if ({add_load, req1_ready, req0_ready} !== 3'b100)
      $display("FAIL basic_load_busy: got %b, required 100", {add_load, req1_ready, req0_ready});
    else pass_cnt++;
    total_cnt++;
    if (add_A !== 32'h7F000000 || add_B !== 32'h7E7E3B78)
      $display("FAIL basic_operands: got %h/%h, required 7f000000/7e7e3b78", add_A, add_B);
    else pass_cnt++;
    @(negedge clk);
    req1_valid = 1'b0;
    total_cnt++;
    if (add_load !== 1'b0) $display("FAIL basic_load_pulse: got %b, required 0", add_load);
    else pass_cnt++;
    wait_resp(rc);
    total_cnt++;
    if (rc - c != 4) $display("FAIL basic_latency: got %0d, required 4", rc - c);
    else pass_cnt++;
    total_cnt++;
    if (load_cnt - loads0 != 1) $display("FAIL basic_load_count: got %0d, required 1", load_cnt - loads0);
    else pass_cnt++;
    total_cnt++;
    if (sb.size() == 0) $display("FAIL basic_resp: got empty queue, required one entry");
    else begin
      e = sb.pop_front();
      if ({resp_id, resp_result, resp_flags} !== e)
        $display("FAIL basic_resp: got %h, required %h", {resp_id, resp_result, resp_flags}, e);
      else pass_cnt++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL basic_release: got %b, required 0", resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_sub();
    int   c, rc;
    exp_t e;
    model_lat = 1;
    submit(1'b1, 32'h7F000007, 32'h7F000007, 1'b1, c);
    total_cnt++;
    if (add_A !== 32'h7F000007 || add_B !== 32'hFF000007)
      $display("FAIL sub_operands: got %h/%h, required 7f000007/ff000007", add_A, add_B);
    else pass_cnt++;
    wait_resp(rc);
    total_cnt++;
    if (resp_flags !== 5'b00100 || resp_result !== '0)
      $display("FAIL sub_zero: got %h/%b, required 00000000/00100", resp_result, resp_flags);
    else pass_cnt++;
    total_cnt++;
    if (sb.size() == 0) $display("FAIL sub_resp: got empty queue, required one entry");
    else begin
      e = sb.pop_front();
      if ({resp_id, resp_result, resp_flags} !== e)
        $display("FAIL sub_resp: got %h, required %h", {resp_id, resp_result, resp_flags}, e);
      else pass_cnt++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    int         rc;
    logic       g;
    logic [1:0] want;
    exp_t       e;
    logic [W-1:0] a0, b0, a1, b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_lat = 2;
    for (int i = 0; i < 4; i++) begin
      g  = i[0];
      a0 = 32'h3F800000 + W'(i); b0 = 32'h00100000 * W'(i + 1);
      a1 = 32'h40400000 + W'(i); b1 = 32'h01000003 + W'(i);
      @(negedge clk);
      req0_valid = 1'b1; req0_a = a0; req0_b = b0; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = a1; req1_b = b1; req1_sub = 1'b0;
      #1;
      want = g ? 2'b10 : 2'b01;
      total_cnt++;
      if ({req1_ready, req0_ready} !== want)
        $display("FAIL arb_grant op%0d: got %b, required %b", i, {req1_ready, req0_ready}, want);
      else pass_cnt++;
      sb.push_back(g ? expect_op(1'b1, a1, b1, 1'b0) : expect_op(1'b0, a0, b0, 1'b0));
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_resp(rc);
      total_cnt++;
      e = sb.pop_front();
      if ({resp_id, resp_result, resp_flags} !== e)
        $display("FAIL arb_resp op%0d: got %h, required %h", i, {resp_id, resp_result, resp_flags}, e);
      else pass_cnt++;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int   c, rc;
    exp_t e;
    model_hang = 1'b1;
    submit(1'b0, 32'h3F800000, 32'h40000000, 1'b0, c);
    void'(sb.pop_back());
    sb.push_back('{id: 1'b0, result: '0, flags: 5'b10000});
    wait_resp(rc);
    total_cnt++;
    if (rc - c != 3 + TO) $display("FAIL timeout_latency: got %0d, required %0d", rc - c, 3 + TO);
    else pass_cnt++;
    total_cnt++;
    e = sb.pop_front();
    if ({resp_id, resp_result, resp_flags} !== e)
      $display("FAIL timeout_resp: got %h, required %h", {resp_id, resp_result, resp_flags}, e);
    else pass_cnt++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    model_hang = 1'b0;
    model_lat  = 3;
    submit(1'b0, 32'h7F800001, 32'h3F800000, 1'b0, c);
    wait_resp(rc);
    total_cnt++;
    if (resp_result !== 32'h7F800001 || resp_flags !== 5'b01000)
      $display("FAIL after_timeout_nan: got %h/%b, required 7f800001/01000", resp_result, resp_flags);
    else pass_cnt++;
    void'(sb.pop_front());
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int   c, rc;
    exp_t e;
    model_lat = 2;
    submit(1'b1, 32'h40A00000, 32'h3E000001, 1'b1, c);
    wait_resp(rc);
    e = sb.pop_front();
    req0_valid = 1'b1; req0_a = 32'h11111111; req0_b = 32'h22222222; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h33333333; req1_b = 32'h44444444; req1_sub = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total_cnt++;
      if ({resp_valid, resp_id, resp_result, resp_flags} !== {1'b1, e} || {req1_ready, req0_ready} !== 2'b00)
        $display("FAIL hold_cycle%0d: got %h ready=%b, required %h ready=00", i,
                 {resp_valid, resp_id, resp_result, resp_flags}, {req1_ready, req0_ready}, {1'b1, e});
      else pass_cnt++;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    total_cnt++;
    if (resp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b01)
      $display("FAIL hold_release: got valid=%b ready=%b, required 0/01", resp_valid, {req1_ready, req0_ready});
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   c, rc;
    logic seen;
    exp_t e;
    model_hang = 1'b1;
    submit(1'b0, 32'h3F800000, 32'h3F800001, 1'b0, c);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h7F000000; req0_b = 32'h7E7E3B78; req0_sub = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({resp_valid, add_load, add_enable, req1_ready, req0_ready, resp_id, resp_flags} !== 11'b0 ||
        add_A !== '0 || add_B !== '0 || resp_result !== '0)
      $display("FAIL midreset_state: got ctrl=%b A=%h B=%h R=%h, required all 0",
               {resp_valid, add_load, add_enable, req1_ready, req0_ready, resp_id, resp_flags}, add_A, add_B, resp_result);
    else pass_cnt++;
    rst = 1'b0;
    model_hang = 1'b0;
    model_lat = 0;
    sb.delete();
    #1;
    total_cnt++;
    if (req0_ready !== 1'b1) $display("FAIL midreset_accept: got %b, required 1", req0_ready);
    else pass_cnt++;
    sb.push_back(expect_op(1'b0, 32'h7F000000, 32'h7E7E3B78, 1'b0));
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(rc);
    total_cnt++;
    e = sb.pop_front();
    if ({resp_id, resp_result, resp_flags} !== e)
      $display("FAIL midreset_resp: got %h, required %h", {resp_id, resp_result, resp_flags}, e);
    else pass_cnt++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | (resp_valid !== 1'b0);
    end
    total_cnt++;
    if (seen) $display("FAIL midreset_phantom: got a response, required none");
    else pass_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sub();
    test_arbitration();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
